// File: rtl/aes_read_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// aes_read_pkg
// Shared types and defaults for the AES read sequencer slice:
//   rs_state_e  - sequencer FSM states (IDLE / SEND)
//   rs_order_e  - lane read order (linear / transposed)
//   DEF_*       - default lane width and state geometry (one AES state)
//   lane_map()  - counter-to-source-lane index mapping
// -----------------------------------------------------------------------------
package aes_read_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rs_state_e;

    typedef enum logic {
        ORD_LINEAR    = 1'b0,
        ORD_TRANSPOSE = 1'b1
    } rs_order_e;

    localparam int unsigned DEF_W    = 32'd8;
    localparam int unsigned DEF_ROWS = 32'd4;
    localparam int unsigned DEF_COLS = 32'd4;

    // The AES state is stored column-major (lane = col*ROWS + row), so a
    // row-major walk visits lane (c % COLS)*ROWS + c / COLS at step c.
    function automatic int unsigned lane_map(
        input int unsigned c,
        input int unsigned rows,
        input int unsigned cols,
        input rs_order_e   ord
    );
        int unsigned idx;
        if (ord == ORD_TRANSPOSE) begin
            idx = (c % cols) * rows + (c / cols);
        end else begin
            idx = c;
        end
        return idx;
    endfunction

endpackage

// File: rtl/aes_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// aes_read_sequencer_if
// Valid/ready lane stream between the read sequencer and the byte-wide
// result/readback consumer.
//   out_valid  - a lane is presented
//   out_ready  - consumer accepts the presented lane
//   out_data   - lane value (W bits)
//   out_idx    - source lane index of out_data
//   out_last   - presented lane is the final lane of the word
// Modports: master = sequencer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface aes_read_sequencer_if #(
    parameter int unsigned W  = 32'd8,
    parameter int unsigned N  = 32'd16,
    parameter int unsigned IW = (N > 32'd1) ? $clog2(N) : 32'd1
);
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/aes_read_sequencer_mux.sv
// -----------------------------------------------------------------------------
// aes_read_mux_n
// Purely combinational N-to-1 mux of W-bit lanes; the generalised form of
// the original 4-to-1 byte read mux.
//   din  - packed lanes, lane k = din[k*W +: W]
//   sel  - lane select
//   dout - selected lane (zero for an out-of-range select)
// -----------------------------------------------------------------------------
module aes_read_mux_n #(
    parameter int unsigned W  = 32'd8,
    parameter int unsigned N  = 32'd16,
    parameter int unsigned IW = (N > 32'd1) ? $clog2(N) : 32'd1
) (
    input  logic [N*W-1:0] din,
    input  logic [IW-1:0]  sel,
    output logic [W-1:0]   dout
);

    logic [W-1:0] lanes_s [N];

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lanes_s[k] = din[k*W +: W];
    end

    // Lane selection; guards select values beyond N-1 for non-power-of-two N.
    always_comb begin
        dout = '0;
        if (32'(sel) < N) begin
            dout = lanes_s[sel];
        end else begin
            dout = '0;
        end
    end

endmodule

// File: rtl/aes_read_sequencer.sv
// -----------------------------------------------------------------------------
// aes_read_sequencer
// Captures an N-lane state word into a shadow register and streams it out one
// lane per valid/ready handshake, in linear or transposed (row-major) order.
// A load on the final handshake chains the next word with no idle bubble.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load, order - capture request for din and its read order
//   din         - N*W state word
//   abort       - synchronous flush to IDLE (highest priority)
//   busy        - shadow register holds undrained data
//   load_drop   - one-cycle pulse after an ignored load
//   stream      - lane stream (master side)
// -----------------------------------------------------------------------------
module aes_read_sequencer
    import aes_read_pkg::*;
#(
    parameter  int unsigned W    = DEF_W,
    parameter  int unsigned ROWS = DEF_ROWS,
    parameter  int unsigned COLS = DEF_COLS,
    localparam int unsigned N    = ROWS * COLS,
    localparam int unsigned IW   = (N > 32'd1) ? $clog2(N) : 32'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 order,
    input  logic [N*W-1:0]       din,
    input  logic                 abort,
    output logic                 busy,
    output logic                 load_drop,
    aes_read_sequencer_if.master stream
);

    localparam logic [IW-1:0] CNT_LAST = IW'(N - 32'd1);

    rs_state_e      state_r;
    rs_state_e      state_s;
    logic [IW-1:0]  cnt_r;
    logic [IW-1:0]  cnt_s;
    rs_order_e      order_r;
    logic [N*W-1:0] shadow_r;
    logic           capture_s;
    logic           drop_r;
    logic           drop_s;
    logic           send_s;
    logic           hs_s;
    logic           last_s;
    logic [IW-1:0]  idx_s;
    logic [W-1:0]   lane_s;

    // Decode of the registered state; no path from out_ready to out_valid.
    always_comb begin
        send_s = (state_r == ST_SEND);
        hs_s   = send_s & stream.out_ready;
        last_s = send_s & (cnt_r == CNT_LAST);
        idx_s  = IW'(lane_map(32'(cnt_r), ROWS, COLS, order_r));
    end

    aes_read_mux_n #(
        .W  (W),
        .N  (N),
        .IW (IW)
    ) u_mux (
        .din  (shadow_r),
        .sel  (idx_s),
        .dout (lane_s)
    );

    // Next-state, counter and capture decisions.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        drop_s    = 1'b0;
        if (abort) begin
            // Abort wins over any load or handshake in the same cycle.
            state_s = ST_IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        capture_s = 1'b1;
                        cnt_s     = '0;
                        state_s   = ST_SEND;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (hs_s && last_s) begin
                        cnt_s = '0;
                        if (load) begin
                            // Back-to-back: next word starts without a bubble.
                            capture_s = 1'b1;
                            state_s   = ST_SEND;
                        end else begin
                            state_s   = ST_IDLE;
                        end
                    end else begin
                        if (hs_s) begin
                            cnt_s = cnt_r + {{(IW-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_s = cnt_r;
                        end
                        drop_s = load;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // FSM state, lane counter, latched order and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            order_r <= ORD_LINEAR;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            drop_r  <= drop_s;
            if (capture_s) begin
                order_r <= rs_order_e'(order);
            end else begin
                order_r <= order_r;
            end
        end
    end

    // Shadow register; only a capture changes it, so a held lane stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else if (capture_s) begin
            shadow_r <= din;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Lane outputs are forced to zero outside SEND so IDLE never shows stale data.
    always_comb begin
        busy             = send_s;
        load_drop        = drop_r;
        stream.out_valid = send_s;
        stream.out_last  = last_s;
        if (send_s) begin
            stream.out_data = lane_s;
            stream.out_idx  = idx_s;
        end else begin
            stream.out_data = '0;
            stream.out_idx  = '0;
        end
    end

endmodule

// File: tb/tb_aes_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_read_sequencer
// Self-checking bench for aes_read_sequencer (default 16 x 8-bit lanes).
// Expected lane streams come from the order rules applied to the loaded word.
// -----------------------------------------------------------------------------
module tb_aes_read_sequencer;
    import aes_read_pkg::*;

    localparam int W    = 8;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load;
    logic           order;
    logic [N*W-1:0] din;
    logic           abort;
    logic           busy;
    logic           load_drop;

    int checks   = 0;
    int failures = 0;

    aes_read_sequencer_if #(.W(W), .N(N)) bus ();

    aes_read_sequencer #(.W(W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .order     (order),
        .din       (din),
        .abort     (abort),
        .busy      (busy),
        .load_drop (load_drop),
        .stream    (bus)
    );

    always #5 clk = ~clk;

    // Reference order: step c of a transposed read walks the rows of the
    // column-major state; linear reads lane c.
    function automatic int ref_idx(input int c, input logic o);
        if (o) return (c % COLS) * ROWS + (c / COLS);
        else   return c;
    endfunction

    function automatic logic [W-1:0] lane_of(input logic [N*W-1:0] w, input int k);
        return w[k*W +: W];
    endfunction

    function automatic logic [N*W-1:0] seq_word(input int base);
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = 8'(base + k);
        return w;
    endfunction

    function automatic logic [N*W-1:0] rand_word();
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = 8'($urandom);
        return w;
    endfunction

    // Expected {valid, data, idx, last} for step c of word w read in order o.
    function automatic logic [13:0] exp_tuple(input logic [N*W-1:0] w, input logic o, input int c);
        int i;
        i = ref_idx(c, o);
        return {1'b1, lane_of(w, i), 4'(i), (c == N - 1)};
    endfunction

    function automatic logic [13:0] got_tuple();
        return {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [N*W-1:0] w, input logic o);
        din   = w;
        order = o;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; order = 1'b0; din = '0; abort = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy, load_drop, got_tuple()} !== 16'h0) begin
            failures++;
            $display("FAIL reset outputs got=%h exp=0000", {busy, load_drop, got_tuple()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, bus.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset busy/valid got=%b exp=00", {busy, bus.out_valid});
        end
    endtask

    task automatic test_drain(input logic o);
        logic [N*W-1:0] w;
        w = seq_word(0);
        bus.out_ready = 1'b1;
        start_word(w, o);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (got_tuple() !== exp_tuple(w, o, c)) begin
                failures++;
                $display("FAIL drain_o%0d c=%0d got=%h exp=%h", o, c, got_tuple(), exp_tuple(w, o, c));
            end
            step();
        end
        checks++;
        if ({busy, bus.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL drain_o%0d_end busy/valid got=%b exp=00", o, {busy, bus.out_valid});
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] w;
        w = seq_word(0);
        bus.out_ready = 1'b1;
        start_word(w, 1'b0);
        for (int c = 0; c < N; c++) begin
            if (c == 5) begin
                bus.out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    checks++;
                    if (got_tuple() !== exp_tuple(w, 1'b0, 5)) begin
                        failures++;
                        $display("FAIL backpressure_hold h=%0d got=%h exp=%h", h, got_tuple(), exp_tuple(w, 1'b0, 5));
                    end
                    step();
                end
                bus.out_ready = 1'b1;
            end
            checks++;
            if (got_tuple() !== exp_tuple(w, 1'b0, c)) begin
                failures++;
                $display("FAIL backpressure c=%0d got=%h exp=%h", c, got_tuple(), exp_tuple(w, 1'b0, c));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] wa;
        logic [N*W-1:0] wb;
        wa = seq_word(0);
        wb = seq_word(8'hA0);
        bus.out_ready = 1'b1;
        start_word(wa, 1'b0);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (got_tuple() !== exp_tuple(wa, 1'b0, c)) begin
                failures++;
                $display("FAIL b2b_a c=%0d got=%h exp=%h", c, got_tuple(), exp_tuple(wa, 1'b0, c));
            end
            if (c == N - 1) begin
                din  = wb;
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if ({busy, got_tuple()} !== {1'b1, exp_tuple(wb, 1'b0, c)}) begin
                failures++;
                $display("FAIL b2b_b c=%0d got=%h exp=%h", c, {busy, got_tuple()}, {1'b1, exp_tuple(wb, 1'b0, c)});
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_drop_abort();
        logic [N*W-1:0] w;
        w = seq_word(0);
        bus.out_ready = 1'b1;
        start_word(w, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if ({load_drop, got_tuple()} !== {(c == 4), exp_tuple(w, 1'b0, c)}) begin
                failures++;
                $display("FAIL drop c=%0d got=%h exp=%h", c, {load_drop, got_tuple()}, {(c == 4), exp_tuple(w, 1'b0, c)});
            end
            if (c == 3) begin
                din  = seq_word(8'h50);
                load = 1'b1;
            end
            if (c == 7) abort = 1'b1;
            step();
            load  = 1'b0;
            abort = 1'b0;
        end
        checks++;
        if ({busy, bus.out_valid, load_drop} !== 3'b000) begin
            failures++;
            $display("FAIL abort busy/valid/drop got=%b exp=000", {busy, bus.out_valid, load_drop});
        end
    endtask

    task automatic test_async_reset();
        logic [N*W-1:0] w;
        w = rand_word();
        bus.out_ready = 1'b1;
        start_word(w, 1'b1);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (got_tuple() !== exp_tuple(w, 1'b1, c)) begin
                failures++;
                $display("FAIL areset_pre c=%0d got=%h exp=%h", c, got_tuple(), exp_tuple(w, 1'b1, c));
            end
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, load_drop, got_tuple()} !== 16'h0) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=0000", {busy, load_drop, got_tuple()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        w = seq_word(8'h30);
        start_word(w, 1'b0);
        checks++;
        if ({busy, got_tuple()} !== {1'b1, exp_tuple(w, 1'b0, 0)}) begin
            failures++;
            $display("FAIL areset_restart got=%h exp=%h", {busy, got_tuple()}, {1'b1, exp_tuple(w, 1'b0, 0)});
        end
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_random();
        logic [N*W-1:0] w;
        logic [N*W-1:0] nw;
        logic           o;
        logic           no;
        logic           chained;
        logic           drop_exp;
        logic           drop_next;
        int             pos;
        int             cyc;
        w = rand_word();
        o = 1'($urandom);
        chained = 1'b0;
        for (int wi = 0; wi < 8; wi++) begin
            if (!chained) start_word(w, o);
            chained  = 1'b0;
            drop_exp = 1'b0;
            pos = 0;
            cyc = 0;
            nw  = '0;
            no  = 1'b0;
            while (pos < N && cyc < 300) begin
                checks++;
                if ({load_drop, got_tuple()} !== {drop_exp, exp_tuple(w, o, pos)}) begin
                    failures++;
                    $display("FAIL random w=%0d pos=%0d got=%h exp=%h", wi, pos, {load_drop, got_tuple()}, {drop_exp, exp_tuple(w, o, pos)});
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
                drop_next = 1'b0;
                if (bus.out_ready && pos == N - 1) begin
                    if (wi < 7 && $urandom_range(0, 1) == 1) begin
                        nw = rand_word();
                        no = 1'($urandom);
                        din = nw;
                        order = no;
                        load = 1'b1;
                        chained = 1'b1;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    din = rand_word();
                    order = 1'($urandom);
                    load = 1'b1;
                    drop_next = 1'b1;
                end
                step();
                load = 1'b0;
                drop_exp = drop_next;
                if (bus.out_ready) pos++;
                cyc++;
            end
            if (pos < N) begin
                checks++;
                failures++;
                $display("FAIL random_timeout w=%0d pos=%0d exp=%0d", wi, pos, N);
            end
            if (!chained) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL random_end w=%0d busy got=%b exp=0", wi, busy);
                end
                w = rand_word();
                o = 1'($urandom);
            end else begin
                w = nw;
                o = no;
            end
        end
    endtask

    initial begin
        test_reset();
        test_drain(1'b0);
        test_drain(1'b1);
        test_backpressure();
        test_back_to_back();
        test_drop_abort();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_read_sequencer.md
# aes_read_sequencer

Parametrised successor to the iterative AES core's 4-to-1 byte read mux. It captures a full N-lane state word (default 16 bytes = one AES state) into a shadow register and streams it out one lane per handshake over a valid/ready port. Lane order is selectable: linear, or transposed (row-major read of the column-major AES state). It sits between the round datapath and the byte-wide result/readback interface, so the core can start the next block while the previous result drains.

## Interface
- `W`, 8, lane width in bits
- `ROWS`, 4, state rows; N = ROWS*COLS lanes
- `COLS`, 4, state columns
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `load`  in  1  capture request for `din`
- `order`  in  1  0 = linear, 1 = transposed; sampled with `load`
- `din`  in  N*W  state word; lane k = `din[k*W +: W]`
- `abort`  in  1  synchronous flush to IDLE
- `busy`  out  1  shadow register holds undrained data
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the current lane
- `out_data`  out  W  current lane
- `out_idx`  out  $clog2(N)  source lane index of `out_data`
- `out_last`  out  1  current lane is the final lane of the word
- `load_drop`  out  1  one-cycle pulse when a `load` is ignored

## Operation
- States: IDLE and SEND.
- IDLE:
  - `load` captures `din` into the shadow register, latches `order`, clears the counter to 0, and moves to SEND.
- SEND:
  - `out_data` = shadow[map(cnt)]; `out_idx` = map(cnt).
  - map(c) = c when order = 0.
  - map(c) = (c % COLS)*ROWS + c / COLS when order = 1, using integer division.
  - A handshake occurs when `out_valid & out_ready`; it increments `cnt`.
  - A handshake with `cnt == N-1` has `out_last` = 1. It returns the block to IDLE, unless `load` is high in the same cycle. In that case the new word is captured and the block stays in SEND with `cnt` = 0. This is the back-to-back case.
- A `load` in SEND other than the last-handshake case is ignored. The shadow register is unchanged and `load_drop` pulses.
- `abort` has priority over `load` and the handshake. It forces IDLE and clears `cnt`. Shadow contents become don't-care.
- `busy` = (state == SEND).
- `out_valid` = (state == SEND).
- `out_data`, `out_idx` and `out_last` are held stable while `out_valid & !out_ready` (AXI-stream style). `out_valid` never drops without a handshake, except on `abort`.
- Counter width is $clog2(N). It never wraps past N-1.
- Reset values: state IDLE, `cnt` 0, shadow 0, latched order 0. Outputs `busy` 0, `out_valid` 0, `out_data` 0, `out_idx` 0, `out_last` 0, `load_drop` 0.
- Reset mid-SEND discards the word immediately (asynchronous).

## Timing
- `load` in cycle t gives `out_valid` = 1 in cycle t+1, with lane map(0) presented.
- With `out_ready` held high, one lane transfers per cycle. N lanes complete in cycles t+1 … t+N.
- Back-to-back: with `load` on the last-handshake cycle, the first lane of the next word appears the following cycle with no bubble.
- Outputs are driven from registered state plus the combinational lane mux. There is no combinational path from `out_ready` to `out_valid`. The path from `out_ready` to `out_data` exists only through the registered `cnt`.
- `abort` in cycle t gives `out_valid` = 0 in cycle t+1.
- `load_drop` is asserted in the cycle after the ignored `load`.

## Structure
- Package `aes_read_pkg`:
  - `typedef enum logic {ST_IDLE, ST_SEND} rs_state_e`
  - `typedef enum logic {ORD_LINEAR, ORD_TRANSPOSE} rs_order_e`
  - localparams for the default W, ROWS and COLS.
- Sub-module `aes_read_mux_n #(W, N)`: purely combinational N-to-1 W-bit mux with a $clog2(N) select. It is the generalisation of the existing 4-to-1 byte mux. The map() index feeds its select.
- The top level holds the FSM, counter, shadow register and index map.

## Test plan
- Linear drain:
  - Stimulus: `din` lanes = 0x00..0x0F, order 0, `out_ready` = 1.
  - Response: `out_data` 0x00, 0x01 … 0x0F on cycles t+1..t+16; `out_last` only on 0x0F; `busy` low at t+17.
- Transposed drain:
  - Stimulus: same `din`, order 1.
  - Response: `out_idx` sequence 0, 4, 8, 12, 1, 5, 9, 13 … 15; `out_data` equals `out_idx`.
- Backpressure:
  - Stimulus: deassert `out_ready` for 3 cycles at lane 5.
  - Response: `out_data` 0x05 and `out_idx` 5 held stable; `out_valid` stays high; the drain resumes at 0x06.
- Back-to-back load:
  - Stimulus: `load` with word B (lanes 0xA0..0xAF) on the lane-15 handshake of word A.
  - Response: the next cycle shows 0xA0 with no IDLE cycle.
- Dropped load and abort:
  - Stimulus: `load` at lane 3.
  - Response: `load_drop` pulses and the stream continues with 0x04.
  - Stimulus: `abort` at lane 7.
  - Response: `out_valid` 0 next cycle; `busy` 0.
- Async reset mid-word:
  - Stimulus: drop `rst_n` at lane 9.
  - Response: all outputs 0 immediately; after release, a fresh `load` starts at lane 0.
